// File: rtl/core_pkg.sv
// core_pkg: shared sequencer state encoding and default bus timeout
package core_pkg;
  typedef enum logic [2:0] {
    FETCH = 3'd0,
    IWAIT = 3'd1,
    EXEC  = 3'd2,
    MREQ  = 3'd3,
    MWAIT = 3'd4,
    WB    = 3'd5,
    HALT  = 3'd6
  } state_t;
  localparam int TIMEOUT_DEF = 255;
endpackage

// File: rtl/core_seq_ctrl_if.sv
// core_seq_ctrl_if: IFU fetch and LSU data handshakes between sequencer (master) and bus units (slave)
//   ifu_req_valid/ifu_req_ready/ifu_resp_valid/inst_we : fetch request, accept, response, IR latch
//   lsu_req_valid/lsu_req_ready/lsu_req_wen/lsu_resp_valid/rdata_we : data request, accept, store flag, response, rdata latch
interface core_seq_ctrl_if;
  logic ifu_req_valid, ifu_req_ready, ifu_resp_valid, inst_we;
  logic lsu_req_valid, lsu_req_ready, lsu_req_wen, lsu_resp_valid, rdata_we;
  modport master (
    output ifu_req_valid, inst_we, lsu_req_valid, lsu_req_wen, rdata_we,
    input  ifu_req_ready, ifu_resp_valid, lsu_req_ready, lsu_resp_valid
  );
  modport slave (
    input  ifu_req_valid, inst_we, lsu_req_valid, lsu_req_wen, rdata_we,
    output ifu_req_ready, ifu_resp_valid, lsu_req_ready, lsu_resp_valid
  );
endinterface

// File: rtl/bus_timeout_cnt.sv
// bus_timeout_cnt: saturating wait counter; expired flags the LIMIT-th waiting cycle
//   clk, rst : clock, async active-high reset
//   clr      : zero the count (held while not waiting)
//   en       : count this cycle as a waiting cycle
//   expired  : current waiting cycle is the LIMIT-th one (or later)
module bus_timeout_cnt #(
  parameter int LIMIT = 255,
  parameter int W     = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en && cnt != W'(LIMIT)) cnt <= cnt + 1'b1;
  // cnt counts cycles already waited, so the current cycle is number cnt+1
  assign expired = en && cnt >= W'(LIMIT - 1);
endmodule

// File: rtl/core_seq_ctrl.sv
// core_seq_ctrl: multi-cycle RV32 sequencer (fetch, exec, mem, writeback) owning all write-enable timing
//   clk, rst   : clock, async active-high reset
//   bus        : IFU/LSU handshakes (master side)
//   is_load/is_store/is_csr/writes_rd/is_ebreak : decoded instruction class, stable from inst_we to next fetch
//   pc_we/rf_we/csr_we : commit strobes, only in WB
//   halted/bus_err     : sticky stop and timeout flags
//   retire_cnt         : retired instructions since reset (wraps)
module core_seq_ctrl
  import core_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  core_seq_ctrl_if.master  bus,
  input  logic             is_load,
  input  logic             is_store,
  input  logic             is_csr,
  input  logic             writes_rd,
  input  logic             is_ebreak,
  output logic             pc_we,
  output logic             rf_we,
  output logic             csr_we,
  output logic             halted,
  output logic             bus_err,
  output logic [CNT_W-1:0] retire_cnt
);
  state_t state, nxt;
  logic mem_ld, mem_st, wait_st, resp, expired, timeout, retire, run;
  assign run     = !rst;
  assign wait_st = state == IWAIT || state == MWAIT;
  assign resp    = state == IWAIT ? bus.ifu_resp_valid : bus.lsu_resp_valid;
  // a response in the expiring cycle takes priority over the timeout
  assign timeout = wait_st && !resp && expired;
  assign retire  = state == WB || (state == EXEC && is_ebreak);
  bus_timeout_cnt #(.LIMIT(TIMEOUT)) u_tmo (
    .clk(clk), .rst(rst), .clr(!wait_st), .en(wait_st), .expired(expired)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= FETCH;
    else state <= nxt;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      bus_err    <= 1'b0;
      mem_ld     <= 1'b0;
      mem_st     <= 1'b0;
      retire_cnt <= '0;
    end else begin
      bus_err <= bus_err | timeout;
      if (state == EXEC) begin
        mem_ld <= is_load;
        mem_st <= is_store;
      end
      if (retire) retire_cnt <= retire_cnt + 1'b1;
    end
  // strobes are gated by rst so an abandoned transaction never writes
  always_comb begin
    nxt = state;
    case (state)
      FETCH:   nxt = bus.ifu_req_ready ? IWAIT : FETCH;
      IWAIT:   nxt = resp ? EXEC : timeout ? HALT : IWAIT;
      EXEC:    nxt = is_ebreak ? HALT : (is_load || is_store) ? MREQ : WB;
      MREQ:    nxt = bus.lsu_req_ready ? MWAIT : MREQ;
      MWAIT:   nxt = resp ? WB : timeout ? HALT : MWAIT;
      WB:      nxt = FETCH;
      default: nxt = HALT;
    endcase
    bus.ifu_req_valid = run && state == FETCH;
    bus.inst_we       = run && state == IWAIT && bus.ifu_resp_valid;
    bus.lsu_req_valid = run && state == MREQ;
    bus.lsu_req_wen   = run && state == MREQ && mem_st;
    bus.rdata_we      = run && state == MWAIT && bus.lsu_resp_valid && mem_ld;
    pc_we             = run && state == WB;
    rf_we             = run && state == WB && writes_rd;
    csr_we            = run && state == WB && is_csr;
    halted            = state == HALT;
  end
endmodule

// File: tb/tb_core_seq_ctrl.sv
// tb_core_seq_ctrl: directed checks of core_seq_ctrl sequencing, strobes, halt, reset and timeout
module tb_core_seq_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic is_load = 1'b0, is_store = 1'b0, is_csr = 1'b0, writes_rd = 1'b0, is_ebreak = 1'b0;
  logic pc_we, rf_we, csr_we, halted, bus_err;
  logic [31:0] retire_cnt;
  int n_vec = 0, n_err = 0;
  int n_cyc, n_inst, n_lv, n_wen, n_rd, n_pc, n_ifv, n_stray;
  logic rf_wb, csr_wb;
  core_seq_ctrl_if bus();
  core_seq_ctrl #(.TIMEOUT(4), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .is_load(is_load), .is_store(is_store), .is_csr(is_csr),
    .writes_rd(writes_rd), .is_ebreak(is_ebreak),
    .pc_we(pc_we), .rf_we(rf_we), .csr_we(csr_we),
    .halted(halted), .bus_err(bus_err), .retire_cnt(retire_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic cyc;
    @(posedge clk);
    #1;
  endtask
  task automatic dec(input logic ld, input logic st, input logic csr, input logic wr, input logic eb);
    is_load = ld; is_store = st; is_csr = csr; writes_rd = wr; is_ebreak = eb;
  endtask
  task automatic idle;
    bus.ifu_req_ready = 0; bus.ifu_resp_valid = 0; bus.lsu_req_ready = 0; bus.lsu_resp_valid = 0;
  endtask
  // Runs one instruction with IFU ready at once and responding one cycle after accept;
  // LSU ready after lrdy valid cycles, response ldly cycles after accept. Stops after pc_we or budget.
  task automatic run(input int lrdy, input int ldly, input int budget);
    int vcnt, lcnt;
    logic ipend, done;
    vcnt = 0; lcnt = 0; ipend = 0;
    n_cyc = 0; n_inst = 0; n_lv = 0; n_wen = 0; n_rd = 0; n_pc = 0; n_ifv = 0; n_stray = 0;
    rf_wb = 0; csr_wb = 0;
    for (int c = 0; c < budget; c++) begin
      bus.ifu_req_ready  = 1;
      bus.ifu_resp_valid = ipend;
      bus.lsu_req_ready  = vcnt >= lrdy;
      bus.lsu_resp_valid = lcnt > 0 && lcnt == ldly;
      #1;
      n_cyc++;
      if (bus.ifu_req_valid) n_ifv++;
      if (bus.inst_we) n_inst++;
      if (bus.rdata_we) n_rd++;
      if (bus.lsu_req_valid) begin
        vcnt++;
        n_lv++;
        if (bus.lsu_req_wen) n_wen++;
      end
      if (pc_we) begin
        n_pc++;
        rf_wb = rf_we;
        csr_wb = csr_we;
      end else if (rf_we || csr_we) n_stray++;
      ipend = bus.ifu_req_valid && bus.ifu_req_ready;
      if (bus.lsu_resp_valid) lcnt = 0;
      else if (bus.lsu_req_valid && bus.lsu_req_ready) lcnt = 1;
      else if (lcnt > 0) lcnt++;
      done = pc_we;
      cyc;
      if (done) break;
    end
    idle;
  endtask
  initial begin
    idle;
    repeat (2) cyc;
    chk("rst_ifu_valid", bus.ifu_req_valid, 0);
    chk("rst_pc_we", pc_we, 0);
    chk("rst_retire", retire_cnt, 0);
    chk("rst_halted", halted, 0);
    chk("rst_bus_err", bus_err, 0);
    rst = 0;
    dec(0, 0, 0, 1, 0);
    bus.ifu_req_ready = 1;
    #1 chk("addi_c1_ifu_valid", bus.ifu_req_valid, 1);
    chk("addi_c1_inst_we", bus.inst_we, 0);
    cyc;
    bus.ifu_req_ready = 0; bus.ifu_resp_valid = 1;
    #1 chk("addi_c2_inst_we", bus.inst_we, 1);
    chk("addi_c2_ifu_valid", bus.ifu_req_valid, 0);
    cyc;
    bus.ifu_resp_valid = 0;
    #1 chk("addi_c3_pc_we", pc_we, 0);
    cyc;
    #1 chk("addi_c4_pc_we", pc_we, 1);
    chk("addi_c4_rf_we", rf_we, 1);
    chk("addi_c4_csr_we", csr_we, 0);
    cyc;
    #1 chk("addi_c5_ifu_valid", bus.ifu_req_valid, 1);
    chk("addi_retire", retire_cnt, 1);
    dec(1, 0, 0, 1, 0);
    run(3, 2, 60);
    chk("lw_cycles", n_cyc, 10);
    chk("lw_lsu_valid_cycles", n_lv, 4);
    chk("lw_wen_cycles", n_wen, 0);
    chk("lw_rdata_we", n_rd, 1);
    chk("lw_rf_we", rf_wb, 1);
    chk("lw_csr_we", csr_wb, 0);
    chk("lw_retire", retire_cnt, 2);
    dec(0, 1, 0, 0, 0);
    run(0, 1, 60);
    chk("sw_cycles", n_cyc, 6);
    chk("sw_wen_cycles", n_wen, 1);
    chk("sw_rdata_we", n_rd, 0);
    chk("sw_rf_we", rf_wb, 0);
    chk("sw_pc_we", n_pc, 1);
    chk("sw_retire", retire_cnt, 3);
    dec(0, 0, 1, 1, 0);
    run(0, 1, 60);
    chk("csr_cycles", n_cyc, 4);
    chk("csr_rf_we", rf_wb, 1);
    chk("csr_csr_we", csr_wb, 1);
    dec(0, 0, 0, 0, 0);
    run(0, 1, 60);
    chk("br_cycles", n_cyc, 4);
    chk("br_pc_we", n_pc, 1);
    chk("br_rf_we", rf_wb, 0);
    chk("br_csr_we", csr_wb, 0);
    chk("br_stray", n_stray, 0);
    chk("br_retire", retire_cnt, 5);
    dec(1, 0, 0, 1, 0);
    bus.ifu_req_ready = 1;
    cyc;
    bus.ifu_req_ready = 0; bus.ifu_resp_valid = 1;
    cyc;
    bus.ifu_resp_valid = 0;
    cyc;
    bus.lsu_req_ready = 1;
    #1 chk("mrst_mreq_valid", bus.lsu_req_valid, 1);
    cyc;
    bus.lsu_req_ready = 0;
    #1 chk("mrst_mwait_rdata", bus.rdata_we, 0);
    rst = 1; bus.lsu_resp_valid = 1;
    #1 chk("mrst_rdata_we", bus.rdata_we, 0);
    chk("mrst_lsu_valid", bus.lsu_req_valid, 0);
    chk("mrst_pc_we", pc_we, 0);
    chk("mrst_rf_we", rf_we, 0);
    chk("mrst_ifu_valid", bus.ifu_req_valid, 0);
    chk("mrst_retire", retire_cnt, 0);
    cyc;
    bus.lsu_resp_valid = 0; rst = 0;
    #1 chk("mrst_refetch", bus.ifu_req_valid, 1);
    dec(0, 0, 0, 1, 0);
    run(0, 1, 60);
    chk("post_rst_retire", retire_cnt, 1);
    bus.ifu_req_ready = 1;
    cyc;
    bus.ifu_req_ready = 0;
    for (int k = 0; k < 4; k++) begin
      #1 chk("tmo_wait_no_err", bus_err, 0);
      cyc;
    end
    #1 chk("tmo_bus_err", bus_err, 1);
    chk("tmo_halted", halted, 1);
    chk("tmo_retire", retire_cnt, 1);
    chk("tmo_pc_we", pc_we, 0);
    chk("tmo_ifu_valid", bus.ifu_req_valid, 0);
    rst = 1;
    cyc;
    rst = 0;
    bus.ifu_req_ready = 1;
    cyc;
    bus.ifu_req_ready = 0;
    repeat (3) cyc;
    bus.ifu_resp_valid = 1;
    #1 chk("late_inst_we", bus.inst_we, 1);
    cyc;
    bus.ifu_resp_valid = 0;
    #1 chk("late_bus_err", bus_err, 0);
    chk("late_halted", halted, 0);
    cyc;
    #1 chk("late_pc_we", pc_we, 1);
    cyc;
    #1 chk("late_retire", retire_cnt, 1);
    dec(0, 0, 0, 0, 1);
    run(0, 1, 100);
    chk("ebreak_pc_we", n_pc, 0);
    chk("ebreak_ifu_valid", n_ifv, 1);
    chk("ebreak_inst_we", n_inst, 1);
    chk("ebreak_halted", halted, 1);
    chk("ebreak_bus_err", bus_err, 0);
    chk("ebreak_retire", retire_cnt, 2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/core_seq_ctrl.md
Name: core_seq_ctrl

Overview:
Multi-cycle sequencer for the single-issue RV32 core. It steps each instruction through fetch, execute, optional memory access and writeback, and drives the write-enables for PC, register file and CSRs. The execute unit stays purely combinational; this block owns all timing.
- Fetch handshake to the IFU.
- Load/store handshake to the LSU, consuming the execute unit's mem_addr/mem_wdata/mem_wmask.
- Halt on ebreak; bus timeout detection; retired-instruction counter.

Parameters:
TIMEOUT, 255, cycles to wait for any bus response before flagging bus_err (1..65535)
CNT_W, 32, width of retired-instruction counter

Ports:
clk  in  1  core clock
rst  in  1  asynchronous, active-high reset
ifu_req_valid  out  1  fetch request valid
ifu_req_ready  in  1  IFU accepts request
ifu_resp_valid  in  1  instruction word available this cycle
inst_we  out  1  latch IFU instruction into the instruction register
is_load  in  1  decoded class: lb/lh/lw/lbu/lhu
is_store  in  1  decoded class: sb/sh/sw
is_csr  in  1  decoded class: csrrw/csrrs
writes_rd  in  1  instruction writes rd (decoder guarantees 0 for rd=x0)
is_ebreak  in  1  ebreak decoded
lsu_req_valid  out  1  data request valid
lsu_req_ready  in  1  LSU accepts request
lsu_req_wen  out  1  1 = store, 0 = load
lsu_resp_valid  in  1  load data ready / store complete
rdata_we  out  1  latch LSU read data into the mem_rdata register
pc_we  out  1  commit next PC
rf_we  out  1  register-file write strobe
csr_we  out  1  CSR write strobe
halted  out  1  sticky; core stopped
bus_err  out  1  sticky; response timeout occurred
retire_cnt  out  CNT_W  instructions retired since reset

Behaviour:
- Reset: state=FETCH; all outputs 0, retire_cnt=0, timeout counter=0. rst is asynchronous; when asserted mid-transaction, outstanding handshakes are abandoned with no write-enables. On release, FETCH is re-entered.
- States: FETCH, IWAIT, EXEC, MREQ, MWAIT, WB, HALT.
- FETCH:
  - ifu_req_valid=1.
  - If ifu_req_ready → IWAIT, else stay.
  - valid is held until ready; the request must not be dropped.
- IWAIT:
  - On ifu_resp_valid: inst_we=1 for that cycle → EXEC.
  - A response arriving in the same cycle as acceptance is not allowed; the IFU response is at least one cycle after accept.
- EXEC (one cycle; decode/exu outputs are stable here):
  - is_ebreak → HALT. No enables; retire_cnt increments once.
  - is_load|is_store → MREQ.
  - Otherwise → WB.
- MREQ:
  - lsu_req_valid=1, lsu_req_wen=is_store.
  - On lsu_req_ready → MWAIT.
  - lsu_req_wen is stable while valid is held.
- MWAIT:
  - On lsu_resp_valid → WB.
  - rdata_we=1 that cycle only if is_load.
- WB (one cycle):
  - pc_we=1.
  - rf_we=writes_rd.
  - csr_we=is_csr.
  - retire_cnt+=1, wrapping modulo 2^CNT_W.
  - → FETCH.
- HALT: terminal. All strobes 0; halted=1; stays until rst.
- Timeout:
  - The counter clears on entry to IWAIT and MWAIT and increments each cycle waiting there.
  - Reaching TIMEOUT with no response → bus_err=1, halted=1, HALT. No write-enables for that instruction; retire_cnt unchanged.
  - A response in the same cycle the count reaches TIMEOUT wins; no error.
  - The counter saturates and never wraps.
- Latency (zero-wait bus, ready=1, response 1 cycle later):
  - ALU/branch/jump/CSR: 4 cycles (FETCH, IWAIT, EXEC, WB).
  - Load/store: 6 cycles.
- Exactly one of pc_we/inst_we/rdata_we-class strobes per instruction step. rf_we and csr_we are only ever high in WB.
- Inputs sampled only in EXEC/WB. The decoder holds them stable from inst_we until the next FETCH.

Decomposition:
- Shared package core_pkg: state encoding enum (3-bit: FETCH=0, IWAIT=1, EXEC=2, MREQ=3, MWAIT=4, WB=5, HALT=6) and the default TIMEOUT constant.
- One natural sub-module: bus_timeout_cnt (clear/enable/saturate counter with `expired` flag), reused by a later IFU/LSU.
- FSM and retire counter stay in core_seq_ctrl.

Test Plan:
- addi with ready=1 and 1-cycle response → inst_we at cycle 2, pc_we+rf_we at cycle 4, retire_cnt=1, ifu_req_valid again at cycle 5.
- lw, LSU ready delayed 3 cycles, response 2 cycles after accept → lsu_req_valid held 4 cycles with wen=0, rdata_we 1 cycle, then WB with rf_we=1 and csr_we=0.
- sw → lsu_req_wen=1, rdata_we never asserted, WB with rf_we=0 and pc_we=1.
- csrrw with writes_rd=1 → rf_we=1 and csr_we=1 in the same WB cycle; branch with writes_rd=0 → pc_we only.
- ebreak → HALT after EXEC, halted=1, retire_cnt incremented, no further ifu_req_valid over 100 cycles; rst mid-MWAIT → all strobes 0, FETCH resumes.
- TIMEOUT=4, ifu_resp_valid never arrives → bus_err=halted=1 exactly 4 cycles after entering IWAIT, retire_cnt unchanged; response on cycle 4 instead → no error.
